// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with programmable signed kernel.
// Line buffers form the window; a 2-stage multiply/sum pipeline follows.
module conv3x3_stream #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned COEF_W = 4,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned OUT_W  = DATA_W + COEF_W + 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              coef_load,
  input  logic [3:0]        coef_idx,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_pixel,
  output logic              frame_done
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic [COEF_W-1:0]        coef    [9];
  logic [COEF_W-1:0]        kc      [9];
  logic [DATA_W-1:0]        win     [9];
  logic [DATA_W-1:0]        lb0     [IMG_W];
  logic [DATA_W-1:0]        lb1     [IMG_W];
  logic signed [PROD_W-1:0] prod_c  [9];
  logic signed [PROD_W-1:0] prod_q  [9];
  logic signed [OUT_W-1:0]  sum_c;
  logic                     win_ok_c;
  logic                     last_c;
  logic                     v0, f0, v1, f1;

  always_comb begin
    win_ok_c = (row >= RW'(2)) && (col >= CW'(2));
    last_c   = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  end

  // Control path: counters, coefficient bank, pipeline valid/frame flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      v0         <= 1'b0;
      f0         <= 1'b0;
      v1         <= 1'b0;
      f1         <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_pixel  <= '0;
      for (int i = 0; i < 9; i++) begin
        coef[i] <= (i == 4) ? COEF_W'(4) : (((i % 2) == 1) ? '1 : '0);
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (coef_load && (coef_idx == 4'(i))) coef[i] <= coef_data;
      end
      if (in_valid) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      v0         <= in_valid && win_ok_c;
      f0         <= in_valid && last_c;
      v1         <= v0;
      f1         <= f0;
      out_valid  <= v1;
      frame_done <= f1;
      if (v1) out_pixel <= sum_c;
    end
  end

  // Data path: the kernel is snapshotted with each accepted pixel so that a
  // write in the same cycle only affects later pixels.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1[col] <= lb0[col];
      lb0[col] <= in_pixel;
      for (int r = 0; r < 3; r++) begin
        win[r*3]     <= win[r*3 + 1];
        win[r*3 + 1] <= win[r*3 + 2];
      end
      win[2] <= lb1[col];
      win[5] <= lb0[col];
      win[8] <= in_pixel;
      for (int i = 0; i < 9; i++) kc[i] <= coef[i];
    end
    for (int i = 0; i < 9; i++) prod_q[i] <= prod_c[i];
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      prod_c[i] = $signed({{COEF_W{1'b0}}, win[i]}) *
                  $signed({{DATA_W{kc[i][COEF_W-1]}}, kc[i]});
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < 9; i++) sum_c = sum_c + OUT_W'(prod_q[i]);
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream: driver pushes hand-derived results,
// a negedge monitor pops and compares value, frame_done and latency.
module tb_conv3x3_stream;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned COEF_W = 4;
  localparam int unsigned OUT_W  = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_pixel;
  logic              coef_load;
  logic [3:0]        coef_idx;
  logic [COEF_W-1:0] coef_data;
  logic              out_valid;
  logic [OUT_W-1:0]  out_pixel;
  logic              frame_done;

  conv3x3_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .coef_load (coef_load),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit fd;
    int acc;
    int r;
    int c;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-derived result at centre (r,c) for each scenario.
  function automatic int hand_exp(input int t, input int r, input int c);
    case (t)
      2, 5: begin
        if (r == 3 && c == 3) return 60;
        if ((c == 3 && (r == 2 || r == 4)) || (r == 3 && (c == 2 || c == 4))) return -15;
        return 0;
      end
      3:       return 9 * c;
      4:       return -1080;
      7:       return 945;
      default: return 0;
    endcase
  endfunction

  function automatic int pix_val(input int t, input int r, input int c);
    case (t)
      2, 5:    return (r == 3 && c == 3) ? 15 : 0;
      3:       return c;
      4, 7:    return 15;
      default: return 5;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic load_coef(input int idx, input int val);
    coef_load = 1'b1;
    coef_idx  = 4'(idx);
    coef_data = COEF_W'(val);
    @(posedge clk); #1;
    coef_load = 1'b0;
  endtask

  task automatic load_all(input int val);
    for (int i = 0; i < 9; i++) load_coef(i, val);
  endtask

  task automatic send_frame(input int t, input int gap);
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        in_valid = 1'b1;
        in_pixel = DATA_W'(pix_val(t, r, c));
        if (r >= 2 && c >= 2) begin
          e.val = hand_exp(t, r - 1, c - 1);
          e.fd  = (r == 7 && c == 7);
          e.acc = cyc + 1;
          e.r   = r - 1;
          e.c   = c - 1;
          sbq.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && sbq.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL drain %s: %0d results still pending, expected 0", name, sbq.size());
      sbq.delete();
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (frame_done && !out_valid) begin
        n_total++;
        $display("FAIL frame_done_alone: frame_done=1 with out_valid=0 at cycle %0d", cyc);
      end
      if (out_valid) begin
        n_total++;
        if (sbq.size() == 0) begin
          $display("FAIL unexpected_out: out_pixel=%0d at cycle %0d, expected no output",
                   $signed(out_pixel), cyc);
        end else begin
          e = sbq.pop_front();
          if ($signed(out_pixel) == e.val && frame_done == e.fd && cyc == e.acc + 2) begin
            n_pass++;
          end else begin
            $display("FAIL out(%0d,%0d): got val=%0d fd=%0b cyc=%0d, expected val=%0d fd=%0b cyc=%0d",
                     e.r, e.c, $signed(out_pixel), frame_done, cyc, e.val, e.fd, e.acc + 2);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    coef_load = 1'b0;
    coef_idx  = '0;
    coef_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_pixel", int'(out_pixel), 0);
    check("reset_frame_done", int'(frame_done), 0);

    // Flat frame under default Laplacian.
    send_frame(1, 0);
    wait_drain("flat_laplacian");

    // Single impulse, continuous then gapped input.
    send_frame(2, 0);
    wait_drain("impulse");
    send_frame(5, 1);
    wait_drain("impulse_gapped");

    // Box kernel; out-of-range indices must not disturb it.
    load_all(1);
    load_coef(9, -8);
    load_coef(12, -8);
    load_coef(15, -8);
    send_frame(3, 0);
    wait_drain("box_ramp");

    // Extremes of the signed range.
    load_all(-8);
    send_frame(4, 0);
    wait_drain("min_extreme");
    load_all(7);
    send_frame(7, 0);
    wait_drain("max_extreme");

    // Partial frame with box kernel, then reset discards it.
    load_all(1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_pixel = DATA_W'(3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_out_pixel", int'(out_pixel), 0);
    send_frame(6, 0);
    wait_drain("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
Streaming 3x3 convolution engine with programmable signed kernel. It generalises the fixed Laplacian stage (centre x4, cross neighbours negated) to a parametrised pixel width, image size and coefficient set. Raster-order pixels enter one per accepted cycle. Two internal line buffers build the 3x3 window, and a 2-stage multiply/accumulate pipeline produces full-precision signed results for interior pixels. It sits between the pixel source and the downstream activation/pooling stages.

Parameters:
DATA_W, 4, unsigned input pixel width
COEF_W, 4, signed kernel coefficient width (two's complement)
IMG_W, 8, pixels per row (>=3)
IMG_H, 8, rows per frame (>=3)
OUT_W, DATA_W+COEF_W+5, output width; full precision, never saturates

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  pixel accepted this cycle when high; no backpressure
in_pixel  in  DATA_W  unsigned pixel, raster order
coef_load  in  1  write one kernel coefficient this cycle
coef_idx  in  4  coefficient index 0..8, row-major (4 = centre)
coef_data  in  COEF_W  signed coefficient value
out_valid  out  1  out_pixel valid this cycle
out_pixel  out  OUT_W  signed convolution result
frame_done  out  1  one-cycle pulse coincident with the frame's last out_valid

Behaviour:
- Reset (rst=1 at edge):
  - out_valid=0, out_pixel=0, frame_done=0.
  - Row/col counters=0; pipeline valid bits cleared.
  - Coefficients restored to Laplacian: idx 4 = +4; idx 1,3,5,7 = -1; idx 0,2,6,8 = 0.
  - Line-buffer and window contents need not be cleared; they are never output before being refilled.
- Counters: col increments on each accepted pixel and wraps IMG_W-1 -> 0, incrementing row. Row wraps IMG_H-1 -> 0, which starts the next frame back-to-back with no idle cycle.
- Window: each accepted pixel shifts into the 3x3 window, together with the same-column pixels from the two line buffers (IMG_W deep each). Cycles with in_valid=0 leave the window, buffers and counters unchanged.
- Output positions: no padding. A window is valid when the accepted pixel has row>=2 and col>=2. Result is centred at (row-1, col-1). Each frame yields (IMG_W-2)*(IMG_H-2) outputs (36 at defaults).
- Pipeline, fixed latency 2:
  - Stage 1 registers nine products, zero-extended pixel times signed coefficient.
  - Stage 2 registers their signed sum to out_pixel.
  - out_valid is asserted exactly 2 cycles after the edge that accepted the completing pixel.
  - The pipeline advances every cycle; valid bits shift regardless of in_valid.
- out_valid=0: out_pixel holds its last value.
- frame_done: asserted with out_valid for the result of pixel (IMG_H-1, IMG_W-1).
- Coefficient write:
  - coef_load=1 with coef_idx<=8 updates that coefficient at the edge.
  - The new value applies to products formed from pixels accepted on later cycles.
  - A pixel accepted in the same cycle as the write uses the old value.
  - coef_idx>=9 is ignored.
  - coef_load is honoured mid-frame.
- Reset mid-frame: the in-flight results are discarded (no out_valid after reset). The next accepted pixel is (0,0) of a new frame.
- Arithmetic: exact at defaults. Range is 9 * 15 * (-8) = -1080 to 9 * 15 * 7 = 945, which fits 13-bit signed.

Test Plan:
1. Reset defaults, continuous 8x8 frame with every pixel 5 -> 36 out_valid pulses, all out_pixel=0. frame_done pulses with the 36th only.
2. Defaults, frame all 0 except pixel 15 at (3,3):
   - out_pixel=+60 at centre (3,3).
   - -15 at (2,3), (4,3), (3,2), (3,4).
   - 0 at all other positions.
3. Load all nine coefs = 1, pixel value = col index -> output centred at column c equals 9*c (9, 18, ... 54) for every row.
4. Coefs all -8, pixels all 15 -> every out_pixel = -1080 with no wrap. Then coefs all +7 -> every out_pixel = +945.
5. Repeat scenario 2 with in_valid toggling every other cycle -> identical value sequence. Each out_valid occurs exactly 2 cycles after its completing pixel is accepted.
6. Load box kernel, stream 20 pixels, assert rst 1 cycle, stream a full frame of 5s -> no out_valid until the 2 cycles after pixel (2,2) is accepted. All outputs are 0 (Laplacian restored) and frame_done is asserted correctly.
